// File: rtl/pc_fetch_unit.sv
// RV32I program-counter and instruction-fetch sequencer with a req/ack imem port.
// Optional MISALIGN_TRAP_EN: a misaligned next PC halts the unit instead of being truncated.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ex_done,
    input  logic        branch,
    input  logic        taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic [31:0] instret,
    output logic        trap
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (jalr)
            next_pc = {alu_result[31:1], 1'b0};
        else if (jal || (branch && taken))
            next_pc = pc + imm;
    end

`ifndef MISALIGN_TRAP_EN
    assign trap = 1'b0;
`endif

    // imem_req / instr_valid are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0000_0013;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            instret     <= '0;
`ifdef MISALIGN_TRAP_EN
            trap        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            trap  <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc       <= next_pc;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
`else
                        pc       <= next_pc & ~32'd3;
                        state    <= FETCH;
                        imem_req <= 1'b1;
`endif
                    end
                end
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; expected values are hand-computed.
// Trap expectations follow MISALIGN_TRAP_EN when the bench is compiled with it.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0013;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ex_done = 1'b0;
    logic        branch = 1'b0;
    logic        taken = 1'b0;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] instret;
    logic        trap;

    int checks = 0;
    int fails  = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .ex_done(ex_done), .branch(branch), .taken(taken), .jal(jal), .jalr(jalr),
        .imm(imm), .alu_result(alu_result), .instret(instret), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0; ex_done = 1'b0;
        branch = 1'b0; taken = 1'b0; jal = 1'b0; jalr = 1'b0; imm = '0; alu_result = '0;
        tick();
        reset = 1'b0;
        tick();  // IDLE -> FETCH
    endtask

    // One accepted fetch: FETCH -> EXEC.
    task automatic fetch_one(input logic [31:0] word);
        imem_ack = 1'b1; imem_rdata = word;
        tick();
        imem_ack = 1'b0;
    endtask

    // One retirement: EXEC -> FETCH (or HALT).
    task automatic exec_one(input logic b, input logic t, input logic j, input logic jr,
                            input logic [31:0] im, input logic [31:0] alu);
        branch = b; taken = t; jal = j; jalr = jr; imm = im; alu_result = alu;
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0; branch = 1'b0; taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; ex_done = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if (instr !== 32'h13) begin fails++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
        checks++; if (instret !== 32'h0) begin fails++; $display("FAIL reset_instret: got %h expected 0", instret); end
        checks++; if (trap !== 1'b0) begin fails++; $display("FAIL reset_trap: got %b expected 0", trap); end
        reset = 1'b0;
        tick();  // ack high in IDLE must not skip FETCH
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL idle_to_fetch: got req=%b valid=%b expected req=1 valid=0", imem_req, instr_valid); end
        imem_ack = 1'b0; ex_done = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
        reset = 1'b1; tick(); reset = 1'b0;
        imem_ack = 1'b1; ex_done = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin fails++; $display("FAIL seq_addr%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 32'(i * 4)); end
            imem_rdata = words[i];
            tick();
            checks++; if (instr_valid !== 1'b1 || instr !== words[i]) begin fails++; $display("FAIL seq_instr%0d: got valid=%b instr=%h expected valid=1 instr=%h", i, instr_valid, instr, words[i]); end
            checks++; if (pc_plus4 !== 32'(i * 4 + 4)) begin fails++; $display("FAIL seq_pcplus4_%0d: got %h expected %h", i, pc_plus4, 32'(i * 4 + 4)); end
            tick();
            checks++; if (instret !== 32'(i + 1)) begin fails++; $display("FAIL seq_instret%0d: got %0d expected %0d", i, instret, i + 1); end
        end
        checks++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL seq_addr3: got %h expected 0000000c", imem_addr); end
        imem_ack = 1'b0; ex_done = 1'b0;
    endtask

    task automatic test_branch();
        do_reset();
        fetch_one(32'h1000_006F);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        checks++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL jal_fwd: got %h expected 00000100", imem_addr); end
        fetch_one(32'h0000_0463);
        // EXEC without ex_done: ack and new rdata must not disturb instr
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr !== 32'h0000_0463 || instr_valid !== 1'b1 || pc !== 32'h100) begin fails++; $display("FAIL exec_hold: got instr=%h valid=%b pc=%h expected 00000463 1 00000100", instr, instr_valid, pc); end
        exec_one(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        checks++; if (imem_addr !== 32'hF8 || imem_req !== 1'b1) begin fails++; $display("FAIL br_taken: got addr=%h req=%b expected 000000f8 1", imem_addr, imem_req); end
        fetch_one(32'h0080_006F);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        fetch_one(32'h0000_0463);
        exec_one(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        checks++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL br_not_taken: got %h expected 00000104", imem_addr); end
    endtask

    task automatic test_priority();
        do_reset();
        fetch_one(32'h0100_006F);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        fetch_one(32'h0000_0067);
        exec_one(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h2001);
        checks++; if (imem_addr !== 32'h2000) begin fails++; $display("FAIL jalr_prio: got %h expected 00002000", imem_addr); end
        fetch_one(32'h0000_0013);
        exec_one(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        checks++; if (imem_addr !== 32'h2004) begin fails++; $display("FAIL taken_no_branch: got %h expected 00002004", imem_addr); end
        fetch_one(32'h0000_0013);
        exec_one(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        checks++; if (imem_addr !== 32'h1FF4) begin fails++; $display("FAIL jal_over_branch: got %h expected 00001ff4", imem_addr); end
    endtask

    task automatic test_misalign();
        do_reset();
        fetch_one(32'h1020_006F);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0);
        checks++; if (instret !== 32'd1) begin fails++; $display("FAIL mis_instret: got %0d expected 1", instret); end
`ifdef MISALIGN_TRAP_EN
        imem_ack = 1'b1; ex_done = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0; ex_done = 1'b0;
        checks++; if (trap !== 1'b1) begin fails++; $display("FAIL mis_trap: got %b expected 1", trap); end
        checks++; if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL mis_halt: got pc=%h req=%b valid=%b expected 0 0 0", pc, imem_req, instr_valid); end
        checks++; if (instret !== 32'd1) begin fails++; $display("FAIL mis_halt_instret: got %0d expected 1", instret); end
`else
        checks++; if (pc !== 32'h100 || imem_req !== 1'b1) begin fails++; $display("FAIL mis_align: got pc=%h req=%b expected 00000100 1", pc, imem_req); end
        checks++; if (trap !== 1'b0) begin fails++; $display("FAIL mis_notrap: got %b expected 0", trap); end
`endif
    endtask

    task automatic test_fetch_stall();
        do_reset();
        fetch_one(32'h0400_006F);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        ex_done = 1'b1; jal = 1'b1; imm = 32'h80;  // ex_done outside EXEC is ignored
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instret !== 32'd1) begin fails++; $display("FAIL stall%0d: got req=%b addr=%h instret=%0d expected 1 00000040 1", i, imem_req, imem_addr, instret); end
            tick();
        end
        ex_done = 1'b0; jal = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h13 || instret !== 32'h0) begin fails++; $display("FAIL stall_reset: got req=%b pc=%h instr=%h instret=%h expected 0 0 00000013 0", imem_req, pc, instr, instret); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_instret_wrap();
        do_reset();
        fetch_one(32'h0000_0013);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        exec_one(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (instret !== 32'h0) begin fails++; $display("FAIL instret_wrap: got %h expected 00000000", instret); end
        checks++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL wrap_addr: got %h expected 00000004", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_misalign();
        test_fetch_stall();
        test_instret_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
